// File: rtl/overlay_result_drain_pkg.sv
// rtl/overlay_result_drain_pkg.sv - shared modes, widths and FIFO entry type for the overlay result drain
package overlay_result_drain_pkg;

  localparam logic [1:0] MODE_1L  = 2'b00;
  localparam logic [1:0] MODE_2L  = 2'b01;
  localparam logic [1:0] MODE_4L  = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  localparam int S_W     = 45;
  localparam int LANE2_W = 22;
  localparam int LANE4_W = 11;
  localparam int CARRY_W = 16;
  localparam int OUT_W   = 46;

  // sgn holds the lane sign interpretation ("signed" is a reserved word)
  typedef struct packed {
    logic [1:0]         mode;
    logic               sgn;
    logic [S_W-1:0]     s;
    logic [CARRY_W-1:0] carry;
  } entry_t;

  // Index of the final lane for a mode; the reserved mode behaves as one lane
  function automatic logic [1:0] lanes_m1(input logic [1:0] mode);
    case (mode)
      MODE_2L: lanes_m1 = 2'd1;
      MODE_4L: lanes_m1 = 2'd3;
      default: lanes_m1 = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/overlay_result_fifo.sv
// rtl/overlay_result_fifo.sv - synchronous entry FIFO with registered occupancy
module overlay_result_fifo
  import overlay_result_drain_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  entry_t        wdata,
  output entry_t        rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  // Fullness is judged on the start-of-cycle count, so a same-cycle pop never frees room
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next storage, pointer and occupancy; pointers wrap naturally at the power-of-two depth
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/overlay_result_drain.sv
// rtl/overlay_result_drain.sv - buffers MAC results and serialises their SIMD lanes onto a stream
module overlay_result_drain
  import overlay_result_drain_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [1:0]         in_mode,
  input  logic               in_signed,
  input  logic [S_W-1:0]     in_s,
  input  logic [CARRY_W-1:0] in_carry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [1:0]         out_lane,
  output logic               out_last,
  output logic [CW-1:0]      fifo_count,
  output logic               overflow,
  output logic               mode_err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         lane_q, lane_d;
  logic               overflow_q, overflow_d;
  logic               mode_err_q, mode_err_d;
  entry_t             wdata, head;
  logic [CW-1:0]      count;
  logic               fifo_full, fifo_empty;
  logic               push_acc, hs, last_lane, pop;
  logic               carry_bit;
  logic [LANE2_W-1:0] lane22;
  logic [LANE4_W-1:0] lane11;
  logic [OUT_W-1:0]   uext, sext;

  assign wdata = '{mode: in_mode, sgn: in_signed, s: in_s, carry: in_carry};

  overlay_result_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign push_acc  = in_valid && !fifo_full;
  assign last_lane = (lane_q == lanes_m1(head.mode));
  assign hs        = (state_q == EMIT) && out_ready;
  assign pop       = hs && last_lane;

  // Lane FSM: walk the head entry's lanes, pop on the last one, continue without a bubble
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          state_d = EMIT;
          lane_d  = '0;
        end
      end
      EMIT: begin
        if (hs) begin
          if (!last_lane) begin
            lane_d = lane_q + 2'd1;
          end else begin
            lane_d  = '0;
            state_d = (count > CW'(1) || push_acc) ? EMIT : IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        lane_d  = '0;
      end
    endcase
  end

  // Sticky error flags; a reserved mode is flagged whether or not the entry fits
  always_comb begin
    overflow_d = overflow_q || (in_valid && fifo_full);
    mode_err_d = mode_err_q || (in_valid && (in_mode == MODE_RSV));
  end

  // Slice the current lane out of the head entry and form both extensions
  always_comb begin
    carry_bit = head.carry[lane_q];
    lane22    = lane_q[0] ? head.s[43:22] : head.s[21:0];
    case (lane_q)
      2'd1:    lane11 = head.s[21:11];
      2'd2:    lane11 = head.s[32:22];
      2'd3:    lane11 = head.s[43:33];
      default: lane11 = head.s[10:0];
    endcase
    case (head.mode)
      MODE_2L: begin
        uext = {23'd0, carry_bit, lane22};
        sext = {{24{lane22[LANE2_W-1]}}, lane22};
      end
      MODE_4L: begin
        uext = {34'd0, carry_bit, lane11};
        sext = {{35{lane11[LANE4_W-1]}}, lane11};
      end
      default: begin
        uext = {carry_bit, head.s};
        sext = {head.s[S_W-1], head.s};
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      overflow_q <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      overflow_q <= overflow_d;
      mode_err_q <= mode_err_d;
    end
  end

  assign out_valid  = (state_q == EMIT);
  assign out_data   = out_valid ? (head.sgn ? sext : uext) : '0;
  assign out_lane   = out_valid ? lane_q : 2'd0;
  assign out_last   = out_valid && last_lane;
  assign fifo_count = count;
  assign overflow   = overflow_q;
  assign mode_err   = mode_err_q;

endmodule

// File: tb/tb_overlay_result_drain.sv
// tb/tb_overlay_result_drain.sv - randomized self-checking bench for overlay_result_drain
module tb_overlay_result_drain;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [1:0]    in_mode;
  logic          in_signed;
  logic [44:0]   in_s;
  logic [15:0]   in_carry;
  logic          out_valid;
  logic          out_ready;
  logic [45:0]   out_data;
  logic [1:0]    out_lane;
  logic          out_last;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          mode_err;

  always #5 clk = ~clk;

  overlay_result_drain #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_mode    (in_mode),
    .in_signed  (in_signed),
    .in_s       (in_s),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_last   (out_last),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .mode_err   (mode_err)
  );

  typedef struct {
    logic [45:0] data;
    logic [1:0]  lane;
    bit          last;
  } word_t;

  word_t wq[$];
  int    occ;
  bit    m_valid, m_ovf, m_merr;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expand an accepted entry into its output words from the lane rules
  function automatic void expand(input logic [1:0] mode, input bit sgn, input logic [44:0] s,
                                 input logic [15:0] c);
    int          n, w;
    logic [63:0] v, mask;
    word_t       wd;
    n    = (mode == 2'b01) ? 2 : (mode == 2'b10) ? 4 : 1;
    w    = (n == 1) ? 45 : (n == 2) ? 22 : 11;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < n; i++) begin
      v = ({19'd0, s} >> (i * w)) & mask;
      if (sgn) begin
        if (v[w-1]) v = v | ~mask;
      end else begin
        v = v | (64'(c[i]) << w);
      end
      wd.data = v[45:0];
      wd.lane = 2'(i);
      wd.last = (i == n - 1);
      wq.push_back(wd);
    end
  endfunction

  // One clock: drive inputs, advance the model to the post-edge state, compare
  task automatic step(input bit rst_n, input bit v, input logic [1:0] m, input bit sg,
                      input logic [44:0] s, input logic [15:0] c, input bit rdy);
    int    prev, pop_e;
    bit    push_ok;
    word_t w;
    reset     = rst_n;
    in_valid  = v;
    in_mode   = m;
    in_signed = sg;
    in_s      = s;
    in_carry  = c;
    out_ready = rdy;
    if (!rst_n) begin
      wq.delete();
      occ = 0; m_valid = 0; m_ovf = 0; m_merr = 0;
    end else begin
      prev  = occ;
      pop_e = 0;
      if (m_valid && rdy && wq.size() > 0) begin
        w = wq.pop_front();
        if (w.last) pop_e = 1;
      end
      if (v && occ == DEPTH) m_ovf = 1;
      if (v && m == 2'b11) m_merr = 1;
      push_ok = v && (occ < DEPTH);
      if (push_ok) expand(m, sg, s, c);
      occ     = occ + int'(push_ok) - pop_e;
      m_valid = (occ > 0) && (prev > 0);
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    check("fifo_count", fifo_count, occ);
    check("overflow", overflow, m_ovf);
    check("mode_err", mode_err, m_merr);
    if (m_valid) begin
      if (wq.size() == 0) begin
        check("model_has_word", 0, 1);
      end else begin
        check("out_data", out_data, wq[0].data);
        check("out_lane", out_lane, wq[0].lane);
        check("out_last", out_last, wq[0].last);
      end
    end
  endtask

  task automatic idle(input bit rdy);
    step(1, 0, 2'b00, 0, 45'd0, 16'd0, rdy);
  endtask

  task automatic push(input logic [1:0] m, input bit sg, input logic [44:0] s,
                      input logic [15:0] c, input bit rdy);
    step(1, 1, m, sg, s, c, rdy);
  endtask

  initial begin
    logic [44:0] s4;
    s4 = 45'h0;
    s4[21:0] = {11'h001, 11'h7FF};

    // Reset held 3 cycles with a valid input that must never emerge
    for (int i = 0; i < 3; i++) step(0, 1, 2'b00, 0, 45'h123, 16'hFFFF, 1);
    check("rst_count", fifo_count, 0);
    check("rst_valid", out_valid, 0);
    idle(1);
    idle(1);
    check("rst_no_entry", out_valid, 0);

    // Mode 00 unsigned with carry[0] and latency
    push(2'b00, 0, 45'h1_0000_0000_05, 16'h0001, 0);
    check("lat_t1", out_valid, 0);
    idle(0);
    check("lat_t2", out_valid, 1);
    check("m00_last", out_last, 1);
    idle(1);
    idle(1);

    // Mode 10 signed: lane0 = -1, lane1 = 1
    push(2'b10, 1, s4, 16'hFFFF, 1);
    idle(1);
    check("m10_lane0", out_data, 46'h3FFF_FFFF_FFFF);
    check("m10_last0", out_last, 0);
    idle(1);
    check("m10_lane1", out_data, 46'h1);
    idle(1);
    idle(1);
    check("m10_last3", out_last, 1);
    idle(1);

    // Backpressure: DEPTH+1 mode 01 pushes with the consumer stalled
    for (int i = 0; i < DEPTH + 1; i++)
      push(2'b01, 0, {$urandom, $urandom}, 16'($urandom), 0);
    check("bp_count", fifo_count, DEPTH);
    check("bp_overflow", overflow, 1);
    for (int i = 0; i < 10; i++) idle(1);
    check("bp_drained", out_valid, 0);

    // Reserved mode behaves as one lane and sets mode_err
    push(2'b11, 0, 45'h5, 16'h0000, 0);
    idle(0);
    check("rsv_data", out_data, 46'h5);
    check("rsv_last", out_last, 1);
    check("rsv_err", mode_err, 1);
    idle(1);
    idle(1);
    check("rsv_sticky", mode_err, 1);

    // Reset while lane 1 of a mode 10 entry is pending
    push(2'b10, 0, {$urandom, $urandom}, 16'($urandom), 0);
    idle(0);
    idle(1);
    check("mid_lane1", out_lane, 1);
    step(0, 0, 2'b00, 0, 45'd0, 16'd0, 0);
    check("mid_valid", out_valid, 0);
    check("mid_count", fifo_count, 0);
    push(2'b10, 1, {$urandom, $urandom}, 16'($urandom), 0);
    idle(0);
    check("mid_new_lane0", out_lane, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 149) != 0), ($urandom_range(0, 2) != 0), 2'($urandom),
           1'($urandom), {$urandom, $urandom}, 16'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Bounded drain
    for (int i = 0; i < 100 && (wq.size() > 0 || occ > 0); i++) idle(1);
    check("drain_words", wq.size(), 0);
    check("drain_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
